// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the round-robin UART arbiter and the UART transmitter.
// A byte is accepted on a cycle with req_valid[i] && req_ready[i]; requesters hold valid and data until then.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic [2:0]         grant_id;
    logic               active;
    logic               err_timeout;
    logic [1:0]         state_dbg;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, active, err_timeout, state_dbg
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, active, err_timeout, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: grant, hold tx_start until busy,
// wait for busy to fall, with a timeout on the start handshake.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [2:0]       gid_q, gid_d;
    logic             err_q, err_d;
    logic             arm_q;
    logic [N_REQ-1:0] ready;
    logic             found;
    logic [2:0]       sel;
    logic [7:0]       sel_data;
    logic [2:0]       next_ptr;

    // Descending scan so the last hit is the one closest to ptr.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_data = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && (i == (int'(ptr_q) + k) % N_REQ)) begin
                    found    = 1'b1;
                    sel      = 3'(i);
                    sel_data = bus.req_data[8*i +: 8];
                end
            end
        end
    end

    assign next_ptr = (gid_q == 3'(N_REQ - 1)) ? 3'd0 : gid_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        gid_d     = gid_q;
        err_d     = 1'b0;
        ready     = '0;
        case (state_q)
            IDLE: begin
                // arm_q blocks a grant on the first edge after reset release.
                if (arm_q && !bus.tx_busy && found) begin
                    ready     = N_REQ'(1) << sel;
                    tx_data_d = sel_data;
                    gid_d     = sel;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            gid_q     <= '0;
            err_q     <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            gid_q     <= gid_d;
            err_q     <= err_d;
            arm_q     <= 1'b1;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = (state_q == START);
    assign bus.grant_id    = gid_q;
    assign bus.active      = (state_q != IDLE);
    assign bus.err_timeout = err_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, busy-at-entry, wrap/skip,
// start timeout, single-byte transfer and reset during WAIT_DONE.
module tb_uart_tx_arbiter;
    localparam int N_REQ        = 4;
    localparam int BUSY_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        bus.req_data[8*i +: 8] = b;
    endtask

    // Starts in an IDLE cycle where the grant is expected; UART raises busy dly cycles
    // after the first START cycle and holds it len cycles. Returns in the next IDLE cycle.
    task automatic xfer(input logic [7:0] d, input int dly, input int len, input bit drop);
        logic [2:0] id;
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 32'(exp_q.size()), 1);
            return;
        end
        id = exp_q.pop_front();
        #1;
        check("grant_ready", 32'(bus.req_ready), 32'(1) << id);
        tick();
        if (drop) bus.req_valid[id] = 1'b0;
        check("s0_ready", 32'(bus.req_ready), 0);
        check("s0_start", 32'(bus.tx_start), 1);
        check("s0_data", 32'(bus.tx_data), 32'(d));
        check("s0_gid", 32'(bus.grant_id), 32'(id));
        check("s0_err", 32'(bus.err_timeout), 0);
        repeat (dly - 1) begin
            tick();
            check("start_hold", 32'(bus.tx_start), 1);
        end
        tick();
        bus.tx_busy = 1'b1;
        #1;
        check("start_at_busy", 32'(bus.tx_start), 1);
        for (int h = 1; h < len; h++) begin
            tick();
            check("wd_start", 32'(bus.tx_start), 0);
            check("wd_active", 32'(bus.active), 1);
            check("wd_ready", 32'(bus.req_ready), 0);
        end
        tick();
        bus.tx_busy = 1'b0;
        #1;
        check("wd_last_active", 32'(bus.active), 1);
        check("wd_last_start", 32'(bus.tx_start), 0);
        check("wd_data", 32'(bus.tx_data), 32'(d));
        tick();
        check("done_active", 32'(bus.active), 0);
        check("done_state", 32'(bus.state_dbg), 0);
        check("done_data", 32'(bus.tx_data), 32'(d));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        #2;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_start", 32'(bus.tx_start), 0);
        check("rst_data", 32'(bus.tx_data), 0);
        check("rst_gid", 32'(bus.grant_id), 0);
        check("rst_active", 32'(bus.active), 0);
        check("rst_err", 32'(bus.err_timeout), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Round robin with all four requesters continuously valid.
        for (int i = 0; i < N_REQ; i++) set_byte(i, 8'(8'h10 + i));
        bus.req_valid = 4'b1111;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        exp_q.push_back(3'd3); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        xfer(8'h10, 1, 3, 1'b0);
        xfer(8'h11, 2, 1, 1'b0);
        xfer(8'h12, 1, 1, 1'b0);
        xfer(8'h13, 3, 2, 1'b0);
        xfer(8'h10, 1, 4, 1'b0);
        xfer(8'h11, 1, 1, 1'b0);

        // Busy at entry: ptr is 2, no grant while busy is high.
        bus.req_valid = 4'b0100;
        set_byte(2, 8'hE7);
        bus.tx_busy   = 1'b1;
        repeat (5) begin
            #1;
            check("busy_idle_ready", 32'(bus.req_ready), 0);
            check("busy_idle_active", 32'(bus.active), 0);
            check("busy_idle_data", 32'(bus.tx_data), 32'h11);
            tick();
        end
        bus.tx_busy = 1'b0;
        exp_q.push_back(3'd2);
        xfer(8'hE7, 2, 2, 1'b1);

        // Wrap/skip from ptr 3 with valid 0101.
        bus.req_valid = 4'b0101;
        set_byte(0, 8'h5A);
        set_byte(2, 8'hC3);
        exp_q.push_back(3'd0);
        xfer(8'h5A, 1, 2, 1'b1);
        exp_q.push_back(3'd2);
        xfer(8'hC3, 2, 1, 1'b1);

        // Timeout: ptr 3, busy never rises for requester 3.
        bus.req_valid = 4'b1010;
        set_byte(3, 8'h77);
        set_byte(1, 8'h21);
        #1;
        check("tmo_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid[3] = 1'b0;
        for (int k = 0; k < BUSY_TIMEOUT; k++) begin
            check("tmo_start", 32'(bus.tx_start), 1);
            check("tmo_err_early", 32'(bus.err_timeout), 0);
            tick();
        end
        check("tmo_err_pulse", 32'(bus.err_timeout), 1);
        check("tmo_start_drop", 32'(bus.tx_start), 0);
        check("tmo_active", 32'(bus.active), 0);
        exp_q.push_back(3'd1);
        xfer(8'h21, 2, 3, 1'b1);
        check("tmo_err_clear", 32'(bus.err_timeout), 0);

        // Single requester 0 with 8'hA5, busy 1 cycle after start for 12 cycles.
        bus.req_valid = 4'b0001;
        set_byte(0, 8'hA5);
        exp_q.push_back(3'd0);
        xfer(8'hA5, 1, 12, 1'b1);

        // Reset during WAIT_DONE; pending requesters 1 and 3.
        bus.req_valid = 4'b0100;
        set_byte(2, 8'h3C);
        set_byte(1, 8'h99);
        #1;
        check("mid_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid[2] = 1'b0;
        bus.tx_busy      = 1'b1;
        tick();
        check("mid_wd_state", 32'(bus.state_dbg), 2);
        bus.req_valid = 4'b1010;
        tick();
        rst_n       = 1'b0;
        bus.tx_busy = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        check("mid_rst_start", 32'(bus.tx_start), 0);
        check("mid_rst_data", 32'(bus.tx_data), 0);
        check("mid_rst_gid", 32'(bus.grant_id), 0);
        check("mid_rst_active", 32'(bus.active), 0);
        check("mid_rst_err", 32'(bus.err_timeout), 0);
        repeat (2) begin
            tick();
            check("rst_hold_err", 32'(bus.err_timeout), 0);
            check("rst_hold_ready", 32'(bus.req_ready), 0);
        end
        rst_n = 1'b1;
        #1;
        check("release_no_grant", 32'(bus.req_ready), 0);
        tick();
        exp_q.push_back(3'd1);
        xfer(8'h99, 1, 2, 1'b1);
        check("final_err", 32'(bus.err_timeout), 0);

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15, max clk cycles waiting for tx_busy to rise after start (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  bit i: requester i has a byte pending.
REQ-006 SHALL have port req_data  input  8*N_REQ  requester i byte at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  N_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-008 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start  output  1  level start request to the UART transmitter.
REQ-010 SHALL have port tx_busy  input  1  UART transmitter busy flag; synchronous to clk.
REQ-011 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-012 SHALL have port active  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port err_timeout  output  1  one-cycle pulse on start-handshake timeout.

Function
REQ-014 SHALL implement states IDLE, START, WAIT_DONE; any unused encoding SHALL return to IDLE next cycle.
REQ-015 In IDLE with tx_busy=0 and any req_valid bit set, the arbiter SHALL grant the first set bit searching ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-016 On grant, req_ready[i] SHALL be 1 in that same cycle, and tx_data and grant_id SHALL be loaded from req_data[i] and i at the clock edge; state SHALL go to START.
REQ-017 A transfer completes on a cycle with req_valid[i]=1 and req_ready[i]=1; the requester SHALL see at most one ready pulse per grant.
REQ-018 In IDLE with tx_busy=1, no grant SHALL be issued, whatever req_valid is.
REQ-019 In START, tx_start SHALL be 1, and a wait counter SHALL increment each cycle starting from 0.
REQ-020 In START, when tx_busy=1 is sampled, tx_start SHALL drop at that edge and state SHALL go to WAIT_DONE.
REQ-021 In START, if the counter reaches BUSY_TIMEOUT with tx_busy still 0, err_timeout SHALL pulse for one cycle, tx_start SHALL drop, state SHALL go to IDLE, and the byte SHALL be discarded.
REQ-022 In WAIT_DONE, tx_start SHALL be 0; when tx_busy=0 is sampled, state SHALL go to IDLE.
REQ-023 On leaving WAIT_DONE or on timeout, ptr SHALL become (grant_id+1) mod N_REQ.
REQ-024 tx_data SHALL stay stable from the grant edge until the next grant.
REQ-025 req_valid changes outside IDLE SHALL be ignored; requesters hold valid until they see ready.
REQ-026 Minimum spacing between grants SHALL be 3 cycles: grant, at least one START cycle, and at least one WAIT_DONE cycle.
REQ-027 active SHALL be 1 in START and WAIT_DONE and 0 in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, ptr 0, counter 0, tx_start 0, req_ready 0, err_timeout 0, tx_data 8'h00, grant_id 0, active 0.
REQ-029 Reset asserted mid-transfer SHALL abort without error pulse; the in-flight byte is lost and is not re-granted.
REQ-030 Reset deassertion SHALL take effect on the first clk edge after rst_n rises; no grant on that edge if req_valid is sampled only then.

Verification
REQ-031 Single requester: valid[0]=1, data 8'hA5; the UART model raises busy 1 cycle after start and holds it 12 cycles -> ready[0] one pulse, tx_data=A5, tx_start high exactly until busy seen, active low after busy falls.
REQ-032 Round-robin fairness: all four valid continuously, each grant index recorded -> grant order 0,1,2,3,0,1 and no requester starved.
REQ-033 Wrap/skip: ptr=3, valid=4'b0101 -> grant 0, then ptr=1 and next grant 2.
REQ-034 Timeout: busy never rises, BUSY_TIMEOUT=15 -> tx_start high 15 cycles, one err_timeout pulse, return to IDLE, ptr advanced, next requester granted.
REQ-035 Busy at entry: tx_busy=1 held 5 cycles in IDLE with valid set -> no ready until busy falls, then grant.
REQ-036 Reset mid-WAIT_DONE: assert rst_n=0 -> all outputs at reset values immediately with no err_timeout; after release, the pending requester is granted from ptr 0.
